// File: rtl/ctrl_seq.sv
// ============================================================================
// ctrl_seq : 5-phase T-state microcode sequencer for the 8-bit CPU.
// Rev 1.0  : initial release.
// ============================================================================
`default_nettype none

module ctrl_seq #(
  parameter int NUM_T = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ir_opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       pc_out,
  output logic       pc_en,
  output logic       pc_jmp,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ram_in,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_in,
  output logic       halt,
  output logic [2:0] t_state
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } t_state_e;

  localparam logic [2:0] T_LAST = 3'(NUM_T - 1);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  t_state_e t_q, t_d;
  logic     halt_q, halt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_q    <= T0;
      halt_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      halt_q <= halt_d;
    end
  end

  // The HLT edge freezes the counter in T2 rather than advancing it.
  always_comb begin
    t_d    = t_q;
    halt_d = halt_q;
    if (!halt_q) begin
      if (t_q == T2 && ir_opcode == OP_HLT) begin
        halt_d = 1'b1;
      end else if (t_q == T_LAST) begin
        t_d = T0;
      end else begin
        t_d = t_state_e'(t_q + 3'd1);
      end
    end
  end

  always_comb begin
    pc_out  = 1'b0;
    pc_en   = 1'b0;
    pc_jmp  = 1'b0;
    mar_in  = 1'b0;
    ram_out = 1'b0;
    ram_in  = 1'b0;
    ir_in   = 1'b0;
    ir_out  = 1'b0;
    a_in    = 1'b0;
    a_out   = 1'b0;
    b_in    = 1'b0;
    alu_out = 1'b0;
    alu_sub = 1'b0;
    out_in  = 1'b0;
    if (rst_n && !halt_q) begin
      case (t_q)
        T0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
        end
        T1: begin
          ram_out = 1'b1;
          ir_in   = 1'b1;
          pc_en   = 1'b1;
        end
        default: begin
          case (ir_opcode)
            OP_LDA: begin
              if (t_q == T2) begin
                ir_out = 1'b1;
                mar_in = 1'b1;
              end else if (t_q == T3) begin
                ram_out = 1'b1;
                a_in    = 1'b1;
              end
            end
            OP_ADD, OP_SUB: begin
              if (t_q == T2) begin
                ir_out = 1'b1;
                mar_in = 1'b1;
              end else if (t_q == T3) begin
                ram_out = 1'b1;
                b_in    = 1'b1;
              end else if (t_q == T4) begin
                alu_out = 1'b1;
                a_in    = 1'b1;
                alu_sub = (ir_opcode == OP_SUB);
              end
            end
            OP_STA: begin
              if (t_q == T2) begin
                ir_out = 1'b1;
                mar_in = 1'b1;
              end else if (t_q == T3) begin
                a_out  = 1'b1;
                ram_in = 1'b1;
              end
            end
            OP_LDI: begin
              if (t_q == T2) begin
                ir_out = 1'b1;
                a_in   = 1'b1;
              end
            end
            // Conditional jumps look at the flags only while in T2.
            OP_JMP, OP_JC, OP_JZ: begin
              if (t_q == T2 &&
                  (ir_opcode == OP_JMP ||
                   (ir_opcode == OP_JC && flag_c) ||
                   (ir_opcode == OP_JZ && flag_z))) begin
                ir_out = 1'b1;
                pc_jmp = 1'b1;
              end
            end
            OP_OUT: begin
              if (t_q == T2) begin
                a_out  = 1'b1;
                out_in = 1'b1;
              end
            end
            OP_NOP, OP_HLT: begin
            end
            default: begin
            end
          endcase
        end
      endcase
    end
  end

  assign halt    = halt_q;
  assign t_state = t_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: a driver pushes expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
`default_nettype none

module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ir_opcode;
  logic       flag_c, flag_z;
  logic pc_out, pc_en, pc_jmp, mar_in, ram_out, ram_in, ir_in, ir_out;
  logic a_in, a_out, b_in, alu_out, alu_sub, out_in, halt;
  logic [2:0] t_state;

  ctrl_seq #(.NUM_T(5)) dut (
    .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode),
    .flag_c(flag_c), .flag_z(flag_z),
    .pc_out(pc_out), .pc_en(pc_en), .pc_jmp(pc_jmp), .mar_in(mar_in),
    .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
    .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
    .alu_sub(alu_sub), .out_in(out_in), .halt(halt), .t_state(t_state)
  );

  always #5 clk = ~clk;

  // Control word bit masks, order {pc_out..out_in}.
  localparam logic [13:0] M_PC_OUT  = 14'b10000000000000;
  localparam logic [13:0] M_PC_EN   = 14'b01000000000000;
  localparam logic [13:0] M_PC_JMP  = 14'b00100000000000;
  localparam logic [13:0] M_MAR_IN  = 14'b00010000000000;
  localparam logic [13:0] M_RAM_OUT = 14'b00001000000000;
  localparam logic [13:0] M_RAM_IN  = 14'b00000100000000;
  localparam logic [13:0] M_IR_IN   = 14'b00000010000000;
  localparam logic [13:0] M_IR_OUT  = 14'b00000001000000;
  localparam logic [13:0] M_A_IN    = 14'b00000000100000;
  localparam logic [13:0] M_A_OUT   = 14'b00000000010000;
  localparam logic [13:0] M_B_IN    = 14'b00000000001000;
  localparam logic [13:0] M_ALU_OUT = 14'b00000000000100;
  localparam logic [13:0] M_ALU_SUB = 14'b00000000000010;
  localparam logic [13:0] M_OUT_IN  = 14'b00000000000001;

  typedef struct packed {
    logic [13:0] cw;
    logic        h;
    logic [2:0]  t;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state.
  bit   m_valid = 0;
  int   m_t     = 0;
  bit   m_h     = 0;
  bit   p_rst   = 0;
  int   p_op    = 0;

  function automatic logic [13:0] ref_cw(int t, bit h, bit r, int op, bit fc, bit fz);
    if (!r || h) return '0;
    if (t == 0) return M_PC_OUT | M_MAR_IN;
    if (t == 1) return M_RAM_OUT | M_IR_IN | M_PC_EN;
    case (op)
      1: if (t == 2) return M_IR_OUT | M_MAR_IN;
         else if (t == 3) return M_RAM_OUT | M_A_IN;
      2, 3: if (t == 2) return M_IR_OUT | M_MAR_IN;
            else if (t == 3) return M_RAM_OUT | M_B_IN;
            else return M_ALU_OUT | M_A_IN | ((op == 3) ? M_ALU_SUB : 14'd0);
      4: if (t == 2) return M_IR_OUT | M_MAR_IN;
         else if (t == 3) return M_A_OUT | M_RAM_IN;
      5: if (t == 2) return M_IR_OUT | M_A_IN;
      6: if (t == 2) return M_IR_OUT | M_PC_JMP;
      7: if (t == 2 && fc) return M_IR_OUT | M_PC_JMP;
      8: if (t == 2 && fz) return M_IR_OUT | M_PC_JMP;
      14: if (t == 2) return M_A_OUT | M_OUT_IN;
      default: ;
    endcase
    return '0;
  endfunction

  // Advance one clock and move the model across that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!p_rst) begin
      m_valid = 1; m_t = 0; m_h = 0;
    end else if (m_valid && !m_h) begin
      if (m_t == 2 && p_op == 15) m_h = 1;
      else m_t = (m_t + 1) % 5;
    end
  endtask

  task automatic apply(bit r, int op, bit fc, bit fz);
    exp_t e;
    rst_n = r; ir_opcode = 4'(op); flag_c = fc; flag_z = fz;
    p_rst = r; p_op = op;
    if (m_valid) begin
      e.cw = ref_cw(m_t, m_h, r, op, fc, fz);
      e.h  = m_h;
      e.t  = 3'(m_t);
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc(bit r, int op, bit fc, bit fz);
    tick();
    apply(r, op, fc, fz);
  endtask

  // Monitor: every cycle with a pending expectation is checked.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [13:0] got;
      int drv;
      e = exp_q.pop_front();
      got = {pc_out, pc_en, pc_jmp, mar_in, ram_out, ram_in, ir_in, ir_out,
             a_in, a_out, b_in, alu_out, alu_sub, out_in};
      drv = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
      total++;
      if (got !== e.cw) begin
        bad++;
        $display("FAIL ctrl_word t=%0d op=%h: got %b want %b", e.t, ir_opcode, got, e.cw);
      end
      total++;
      if (halt !== e.h) begin
        bad++;
        $display("FAIL halt: got %b want %b", halt, e.h);
      end
      total++;
      if (t_state !== e.t) begin
        bad++;
        $display("FAIL t_state: got %0d want %0d", t_state, e.t);
      end
      total++;
      if (drv > 1 || (pc_en && pc_jmp)) begin
        bad++;
        $display("FAIL bus_excl: got drivers=%0d en/jmp=%b%b want <=1 and not both", drv, pc_en, pc_jmp);
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; ir_opcode = '0; flag_c = 1'b0; flag_z = 1'b0;
    p_rst = 0; p_op = 0;

    // Reset, then free-run NOP.
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0);

    // ADD then SUB, aligned to T0.
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 2, $urandom_range(0, 1), $urandom_range(0, 1));
    for (int i = 0; i < 5; i++) cyc(1, 3, $urandom_range(0, 1), $urandom_range(0, 1));

    // JC / JZ with flags changing every cycle.
    for (int i = 0; i < 20; i++) cyc(1, 7, $urandom_range(0, 1), $urandom_range(0, 1));
    for (int i = 0; i < 20; i++) cyc(1, 8, $urandom_range(0, 1), $urandom_range(0, 1));

    // HLT, then 20 halted cycles with noise on the inputs, then reset pulse.
    n = 0;
    do begin
      cyc(1, 15, 0, 0);
      n++;
    end while (!m_h && n < 12);
    total++;
    if (!m_h) begin
      bad++;
      $display("FAIL halt_entry: got no halt want halt within 12 cycles");
    end
    for (int i = 0; i < 20; i++) cyc(1, $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1));
    cyc(0, 15, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);

    // Reset asserted in T3 of LDA.
    cyc(0, 1, 0, 0);
    n = 0;
    forever begin
      tick();
      if (m_t == 3 || n > 10) break;
      apply(1, 1, 0, 0);
      n++;
    end
    apply(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0);

    // Every opcode x flag value through all five T-states.
    for (int op = 0; op < 16; op++) begin
      for (int f = 0; f < 2; f++) begin
        cyc(0, op, f[0], f[0]);
        for (int t = 0; t < 5; t++) cyc(1, op, f[0], f[0]);
      end
    end

    // Random traffic with occasional reset.
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1));

    tick();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ctrl_seq.md
# ctrl_seq

Microcode sequencer for the 8-bit CPU. It steps a five-phase T-state counter and decodes the 4-bit instruction opcode plus ALU flags into the per-cycle control word. That control word includes the program counter's `pc_out`, `pc_en` and `pc_jmp` strobes. It is the initiator of every bus transfer: it decides which register drives the shared bus and which register captures it.

## Interface
Parameters:
- `NUM_T`, default 5: T-states per instruction. Fixed; no other value is supported.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; **synchronous, active-low**.
- `ir_opcode`  in  4  high nibble of the instruction register.
- `flag_c`  in  1  registered ALU carry flag.
- `flag_z`  in  1  registered ALU zero flag.
- `pc_out`  out  1  PC drives its 4-bit value onto the bus.
- `pc_en`  out  1  PC increments at the next edge.
- `pc_jmp`  out  1  PC loads from the bus at the next edge.
- `mar_in`  out  1  memory address register loads from the bus.
- `ram_out`  out  1  RAM drives the bus.
- `ram_in`  out  1  RAM writes the bus value.
- `ir_in`  out  1  IR loads from the bus.
- `ir_out`  out  1  IR drives its low nibble (operand) onto the bus.
- `a_in`  out  1  A register loads.
- `a_out`  out  1  A register drives the bus.
- `b_in`  out  1  B register loads.
- `alu_out`  out  1  ALU result drives the bus.
- `alu_sub`  out  1  ALU subtracts instead of adding.
- `out_in`  out  1  output register loads.
- `halt`  out  1  CPU halted (registered, sticky).
- `t_state`  out  3  current T-state, 0..4, for debug.

## Operation
- The T-state counter is 3 bits and counts 0→1→2→3→4→0. The 4→0 wrap has no gap. Every instruction takes exactly 5 cycles.
- Control outputs are a combinational decode of `t_state`, `ir_opcode`, `flag_c`, `flag_z` and `halt`. Any output not listed for a step is 0.
- Fetch phase, common to all opcodes:
  - T0: `pc_out`, `mar_in`.
  - T1: `ram_out`, `ir_in`, `pc_en`.
- Execute phase, T2–T4, by opcode:
  - 0x0 NOP: nothing.
  - 0x1 LDA:
    - T2: `ir_out`, `mar_in`.
    - T3: `ram_out`, `a_in`.
  - 0x2 ADD:
    - T2: `ir_out`, `mar_in`.
    - T3: `ram_out`, `b_in`.
    - T4: `alu_out`, `a_in`.
  - 0x3 SUB: as ADD, with `alu_sub` also asserted in T4.
  - 0x4 STA:
    - T2: `ir_out`, `mar_in`.
    - T3: `a_out`, `ram_in`.
  - 0x5 LDI:
    - T2: `ir_out`, `a_in`.
  - 0x6 JMP:
    - T2: `ir_out`, `pc_jmp`.
  - 0x7 JC:
    - T2: `ir_out`, `pc_jmp`, only if `flag_c` = 1; otherwise nothing.
  - 0x8 JZ:
    - T2: `ir_out`, `pc_jmp`, only if `flag_z` = 1; otherwise nothing.
  - 0xE OUT:
    - T2: `a_out`, `out_in`.
  - 0xF HLT:
    - T2: no bus controls; `halt` is set at the end of T2.
  - 0x9–0xD: treated as NOP.
- Bus-driver invariant: at most one of `pc_out`, `ram_out`, `ir_out`, `a_out`, `alu_out` is 1 in any cycle.
- `pc_en` and `pc_jmp` are never 1 in the same cycle.
- Halt behaviour:
  - Once `halt` = 1, `t_state` freezes at its current value (2 after the halt edge) and all control outputs read 0.
  - Halt is left only through reset.

## Timing
- Reset, on a rising edge with `rst_n` = 0:
  - `t_state` ← 0 and `halt` ← 0.
  - While `rst_n` is low, all control outputs are forced to 0 combinationally.
- First cycle after `rst_n` rises: T0, with `pc_out` and `mar_in` asserted.
- Reset mid-instruction, at any T-state or while halted:
  - The next cycle is T0.
  - No partial instruction resumes.
- Flags are sampled combinationally during T2 only. A flag change in other cycles has no effect on the jump decision.
- The opcode is read from T2 to T4. The IR is written in T1, so the opcode is stable by T2.
- `halt` is a registered output. It is 0 during the HLT T2 cycle and 1 from the following cycle onward.
- Throughput: one instruction per 5 cycles. The PC increments exactly once per instruction, at the end of T1.

## Test plan
- Reset then free-run with `ir_opcode` = 0x0:
  - `t_state` sequence is 0,1,2,3,4,0,…
  - `pc_out` & `mar_in` are high only in T0.
  - `pc_en` is high only in T1, i.e. once every 5 cycles.
- `ir_opcode` = 0x2 (ADD), then 0x3 (SUB):
  - T2 = {`ir_out`, `mar_in`}, T3 = {`ram_out`, `b_in`}, T4 = {`alu_out`, `a_in`}.
  - `alu_sub` = 1 only in T4 of SUB.
  - The single-bus-driver check passes every cycle.
- `ir_opcode` = 0x7 (JC):
  - With `flag_c` = 0: `pc_jmp` = 0 in T2.
  - With `flag_c` = 1: `pc_jmp` = 1 and `ir_out` = 1 in T2.
  - Toggling `flag_c` in T3 does nothing.
  - Same check for 0x8 (JZ) with `flag_z`.
- `ir_opcode` = 0xF (HLT):
  - `halt` is 0 in T2 and 1 from the next cycle.
  - `t_state` holds at 2 and all control outputs stay 0 for 20 cycles.
  - Pulse `rst_n` low for 1 edge: `halt` = 0, T0 follows.
- Assert `rst_n` = 0 during T3 of LDA:
  - Outputs are 0 during reset.
  - After release, `t_state` = 0 with `pc_out` = 1.
  - No `a_in` pulse occurs for the aborted LDA.
- Loop all 16 opcodes × 5 T-states × both flag values:
  - Compare against the decode list above.
  - 0x9–0xD give an all-zero T2–T4.
